nibble_sub_seq: RTL and testbench
=================================

Name: nibble_sub_seq

Overview:
- Multi-nibble sequential subtractor: computes in_data1 - in_data2 over NIBBLES*4-bit operands, one 4-bit nibble per clock, LSB nibble first.
- The borrow is held in a flop between nibbles.
- Inverse-direction companion to the team's 4-bit adder datapath; sits beside it in the arithmetic block set and drives a borrow flag the same way the adder drives cy.
- start/busy/done handshake with the controlling FSM.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (operand width W = 4*NIBBLES); legal range 1..16

Ports:
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- in_data1  input  W  minuend; sampled on the start-accept edge only
- in_data2  input  W  subtrahend; sampled on the start-accept edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result valid
- out_data  output  W  difference; held until next accepted start
- bw  output  1  borrow out (1 when in_data1 < in_data2, unsigned)
- zero  output  1  1 when out_data == 0

Behaviour:
- Reset (rst high at a clk edge, from any state, including mid-RUN):
  - state=IDLE; busy=0, done=0, out_data=0, bw=0, zero=0.
  - Internal borrow, nibble index and operand regs cleared; any operation in progress is discarded.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0: latch both operands, index=0, borrow=0, busy=1, state=RUN.
  - start=0: stay in IDLE; outputs hold.
- RUN, edges E1..EN (one per nibble, index 0..NIBBLES-1):
  - d = a[i] - b[i] - borrow, computed 5 bits wide.
  - Write d[3:0] into out_data nibble i.
  - borrow <= d[4].
  - index increments.
- On edge EN:
  - State becomes DONE; busy=0, done=1.
  - bw = final borrow; zero = (full result == 0).
- DONE: at the next edge, done=0 and state=IDLE. done is high for exactly one cycle.
- Latency:
  - done is high in the cycle following edge E(NIBBLES), i.e. NIBBLES+1 edges after the start-accept edge.
  - Throughput: one operation per NIBBLES+2 cycles.
- start while in RUN or DONE: ignored; not queued. Operands on in_data* are don't-care outside the accept edge.
- Output update rules:
  - out_data nibbles update progressively during RUN; they are valid only when done=1 and afterwards.
  - bw and zero update only on edge EN and hold until the next EN or reset.
- Arithmetic: unsigned modulo 2^W. out_data = (in_data1 - in_data2) mod 2^W; bw = borrow out of the MSB nibble.
- NIBBLES=1: RUN lasts a single cycle; otherwise identical behaviour.

Optional Feature:
- Macro: NIBBLE_SUB_SAT_EN
- Defined:
  - Result saturates at zero: on edge EN, if the final borrow=1, out_data is forced to 0 and zero=1; bw is still reported as 1.
  - The forcing is applied on the same edge that raises done; latency is unchanged.
- Undefined: wrap-around modulo 2^W as above; no saturation logic is present.

Test Plan (NIBBLES=4):
- 1. start, in_data1=16'h1234, in_data2=16'h0034 -> done exactly 5 edges after accept; out_data=16'h1200, bw=0, zero=0.
- 2. in_data1=16'h8000, in_data2=16'h0001 (borrow ripples through nibbles 0..2) -> out_data=16'h7FFF, bw=0, zero=0.
- 3. in_data1=16'h0000, in_data2=16'h0001:
  - Macro undefined -> out_data=16'hFFFF, bw=1, zero=0.
  - NIBBLE_SUB_SAT_EN defined -> out_data=16'h0000, bw=1, zero=1.
- 4. in_data1=in_data2=16'hA5A5 -> out_data=16'h0000, bw=0, zero=1.
- 5. Accept start with 16'h0010-16'h0001; hold start=1 with different operands through RUN and DONE:
  - Only one done pulse; out_data=16'h000F.
  - Next start is accepted no earlier than the first IDLE cycle.
- 6. Assert rst for one edge at RUN index 2 -> next cycle busy=0, done=0, out_data=0, bw=0, zero=0, state IDLE; no done pulse follows; a subsequent start operates normally.

Source files
------------

// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: multi-nibble sequential subtractor.
//   Computes in_data1 - in_data2 over W = 4*NIBBLES bit operands, one nibble
//   per clock, least significant nibble first. The borrow is held in a flop
//   between nibbles.
//   Handshake: start is accepted in IDLE. busy is high during RUN. done pulses
//   for one cycle when the result is valid.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start                operation request, sampled only in IDLE
//   in_data1, in_data2   minuend / subtrahend, latched on the accept edge
//   busy, done           status; done is a one-cycle pulse
//   out_data             difference, held until the next accepted start
//   bw                   borrow out of the MSB nibble (in_data1 < in_data2)
//   zero                 out_data == 0
// Optional build macro NIBBLE_SUB_SAT_EN: the result saturates at zero when
//   the final borrow is set. bw is still reported as 1.
module nibble_sub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   in_data1,
    input  logic [4*NIBBLES-1:0]   in_data2,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic                   bw,
    output logic                   zero
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_reg, b_reg;
    logic [IDX_W-1:0] idx;
    logic             borrow;

    logic [3:0]       a_nib, b_nib;
    logic [4:0]       diff;
    logic [W-1:0]     res_next;
    logic             last;

    // Current nibble slice and its 5-bit difference; bit 4 is the borrow out.
    // res_next is out_data with nibble idx replaced by the new digit.
    always_comb begin
        a_nib    = 4'(a_reg >> {idx, 2'b00});
        b_nib    = 4'(b_reg >> {idx, 2'b00});
        diff     = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0, borrow};
        res_next = (out_data & ~(W'(4'hF) << {idx, 2'b00}))
                 | (W'(diff[3:0]) << {idx, 2'b00});
        last     = (idx == IDX_W'(NIBBLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= '0;
            borrow   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_data <= '0;
            bw       <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= in_data1;
                        b_reg  <= in_data2;
                        idx    <= '0;
                        borrow <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    borrow <= diff[4];
                    idx    <= idx + IDX_W'(1);
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bw    <= diff[4];
                        state <= DONE;
`ifdef NIBBLE_SUB_SAT_EN
                        // A final borrow means the true difference is negative.
                        if (diff[4]) begin
                            out_data <= '0;
                            zero     <= 1'b1;
                        end else begin
                            out_data <= res_next;
                            zero     <= (res_next == '0);
                        end
`else
                        out_data <= res_next;
                        zero     <= (res_next == '0);
`endif
                    end else begin
                        out_data <= res_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_sub_seq.sv
module tb_nibble_sub_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in_data1, in_data2;
    logic         busy, done, bw, zero;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_fail = 0;

    nibble_sub_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data1(in_data1), .in_data2(in_data2),
        .busy(busy), .done(done), .out_data(out_data), .bw(bw), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned subtraction on whole operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic bo, output logic z);
        bo = (a < b);
        r  = a - b;
`ifdef NIBBLE_SUB_SAT_EN
        if (bo) r = '0;
`endif
        z = (r == '0);
    endtask

    // Launch one operation from IDLE, check latency, result and done pulse width.
    // Drives at negedge, samples at negedge. Returns with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic eb, ez;
        int edges;
        model(a, b, er, eb, ez);
        start = 1'b1; in_data1 = a; in_data2 = b;
        @(posedge clk); @(negedge clk);
        start = 1'b0; in_data1 = $urandom; in_data2 = $urandom;
        chk({tag, ".busy"}, busy, 1'b1);
        edges = 1;
        while (!done && edges < 3 * N + 10) begin
            @(posedge clk); @(negedge clk);
            edges++;
        end
        chk({tag, ".done_seen"}, done, 1'b1);
        chk({tag, ".latency"}, edges, N + 1);
        chk({tag, ".out"}, out_data, er);
        chk({tag, ".bw"}, bw, eb);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
        @(posedge clk); @(negedge clk);
        chk({tag, ".done_pulse"}, done, 1'b0);
        chk({tag, ".hold"}, out_data, er);
    endtask

    initial begin
        logic [W-1:0] er;
        logic eb, ez;
        int dones;
        rst = 1'b1; start = 1'b0; in_data1 = '0; in_data2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.out", out_data, '0);
        chk("rst.bw", bw, 1'b0);
        chk("rst.zero", zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the plan.
        run_op("t1", 16'h1234, 16'h0034);
        run_op("t2", 16'h8000, 16'h0001);
        run_op("t3", 16'h0000, 16'h0001);
        run_op("t4", 16'hA5A5, 16'hA5A5);
        run_op("t4b", 16'hFFFF, 16'hFFFF);
        run_op("t4c", 16'h0000, 16'hFFFF);

        // Start held through RUN and DONE: one done pulse, then re-accept in IDLE.
        start = 1'b1; in_data1 = 16'h0010; in_data2 = 16'h0001;
        @(posedge clk); @(negedge clk);
        dones = 0;
        for (int i = 0; i < N; i++) begin
            in_data1 = $urandom; in_data2 = $urandom;
            @(posedge clk); @(negedge clk);
            if (done) dones++;
        end
        chk("t5.done_seen", done, 1'b1);
        chk("t5.out", out_data, 16'h000F);
        in_data1 = 16'h0300; in_data2 = 16'h0100;
        @(posedge clk); @(negedge clk);           // DONE -> IDLE, start ignored
        if (done) dones++;
        chk("t5.not_accepted_in_done", busy, 1'b0);
        chk("t5.one_pulse", dones, 1);
        @(posedge clk); @(negedge clk);           // first IDLE edge accepts
        start = 1'b0;
        chk("t5.accept_idle", busy, 1'b1);
        for (int i = 0; i < N; i++) begin @(posedge clk); @(negedge clk); end
        chk("t5.second_done", done, 1'b1);
        chk("t5.second_out", out_data, 16'h0200);
        @(posedge clk); @(negedge clk);

        // Reset mid-RUN at nibble index 2.
        start = 1'b1; in_data1 = 16'h0000; in_data2 = 16'h1111;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("t6.busy", busy, 1'b0);
        chk("t6.done", done, 1'b0);
        chk("t6.out", out_data, '0);
        chk("t6.bw", bw, 1'b0);
        chk("t6.zero", zero, 1'b0);
        dones = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk); @(negedge clk);
            if (done || busy) dones++;
        end
        chk("t6.quiet", dones, 0);
        run_op("t6.after", 16'h4321, 16'h1234);

        // Random operations, with occasional idle gaps.
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = (k % 5 == 0) ? a : W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op("rnd", a, b);
        end

        model(16'h1234, 16'h1234, er, eb, ez);
        chk("model.sanity_zero", ez, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
